// File: rtl/coax_link_pkg.sv
// Shared types and helpers for the coax half-duplex line controller.
package coax_link_pkg;

   // Width of one coax word as delivered by coax_rx.
   localparam int unsigned WordWidth = 10;

   typedef enum logic [2:0] {
      StIdle,
      StTx,
      StTurnaround,
      StWaitResp,
      StReceive,
      StDone
   } link_state_e;

   // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/coax_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible on rdata without a pop.
// Depth must be a power of two so the pointers wrap naturally.
module coax_fifo #(
   parameter int unsigned Width = 10,
   parameter int unsigned Depth = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic [Width-1:0]         wdata,
   input  logic                     pop,
   output logic [Width-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam logic [AddrW:0] FullCount = (AddrW + 1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AddrW:0]   count_q, count_d;
   logic             empty_q;
   logic             do_push, do_pop;

   assign full    = (count_q == FullCount);
   assign do_pop  = pop && !empty_q;
   // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
   assign do_push = push && (!full || do_pop);

   // Next occupancy from the effective push/pop pair.
   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer, occupancy and empty-flag registers.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         empty_q <= (count_d == '0);
      end
   end

   // Storage array; contents need no reset because empty masks the head.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = empty_q ? '0 : mem_q[rd_ptr_q];
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/coax_link_ctrl.sv
// Half-duplex coax line controller: transmit, turnaround, wait for response, receive.
// Keeps coax_rx in reset whenever the line is not listening, buffers received words.
// Optional build macro COAX_LINK_ERROR_ABORT_EN: the first rx_error in RECEIVE ends
// the transaction at once and drops the word strobed with it.
module coax_link_ctrl
   import coax_link_pkg::*;
#(
   parameter int unsigned TURNAROUND_CLOCKS       = 16,
   parameter int unsigned RESPONSE_TIMEOUT_CLOCKS = 512,
   parameter int unsigned FIFO_DEPTH              = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          abort,
   output logic                          busy,
   output logic                          done,
   input  logic                          tx_active,
   output logic                          rx_reset,
   input  logic                          rx_active,
   input  logic [WordWidth-1:0]          rx_data,
   input  logic                          rx_strobe,
   input  logic                          rx_error,
   output logic [WordWidth-1:0]          fifo_data,
   output logic                          fifo_empty,
   input  logic                          fifo_read,
   output logic [$clog2(FIFO_DEPTH):0]   word_count,
   output logic                          timeout,
   output logic                          error,
   output logic                          overflow
);

   localparam int unsigned TurnW = cnt_width(TURNAROUND_CLOCKS);
   localparam int unsigned RespW = cnt_width(RESPONSE_TIMEOUT_CLOCKS);
   localparam int unsigned CntW  = (TurnW > RespW) ? TurnW : RespW;
   localparam logic [CntW-1:0] TurnLast = CntW'(TURNAROUND_CLOCKS - 1);
   localparam logic [CntW-1:0] RespLast = CntW'(RESPONSE_TIMEOUT_CLOCKS - 1);

   link_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            seen_q, seen_d;   // tx_active high observed in this TX phase
   logic            timeout_q, timeout_d;
   logic            error_q, error_d;
   logic            overflow_q, overflow_d;
   logic            busy_q, done_q, rx_reset_q;
   logic            fifo_push, fifo_clear, fifo_full;

   // Next-state, counter, status and FIFO control decode.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      seen_d     = seen_q;
      timeout_d  = timeout_q;
      error_d    = error_q;
      overflow_d = overflow_q;
      fifo_push  = 1'b0;
      fifo_clear = 1'b0;

      if (abort) begin
         // Abort beats everything, including start; FIFO and status are kept.
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d    = StTx;
                  seen_d     = 1'b0;
                  fifo_clear = 1'b1;
                  timeout_d  = 1'b0;
                  error_d    = 1'b0;
                  overflow_d = 1'b0;
               end
            end
            StTx: begin
               if (tx_active) begin
                  seen_d = 1'b1;
               end else if (seen_q) begin
                  state_d = StTurnaround;
                  cnt_d   = '0;
               end
            end
            StTurnaround: begin
               if (cnt_q == TurnLast) begin
                  state_d = StWaitResp;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StWaitResp: begin
               if (rx_active) begin
                  state_d = StReceive;
               end else if (cnt_q == RespLast) begin
                  timeout_d = 1'b1;
                  state_d   = StDone;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StReceive: begin
`ifdef COAX_LINK_ERROR_ABORT_EN
               if (rx_error) begin
                  error_d = 1'b1;
                  state_d = StDone;
               end else begin
                  fifo_push = rx_strobe;
                  if (rx_strobe && fifo_full && !fifo_read) overflow_d = 1'b1;
                  if (!rx_active) state_d = StDone;
               end
`else
               if (rx_error) error_d = 1'b1;
               fifo_push = rx_strobe;
               if (rx_strobe && fifo_full && !fifo_read) overflow_d = 1'b1;
               if (!rx_active) state_d = StDone;
`endif
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // State, counter, status and registered output flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         seen_q     <= 1'b0;
         timeout_q  <= 1'b0;
         error_q    <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rx_reset_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         seen_q     <= seen_d;
         timeout_q  <= timeout_d;
         error_q    <= error_d;
         overflow_q <= overflow_d;
         busy_q     <= (state_d != StIdle);
         done_q     <= (state_d == StDone);
         rx_reset_q <= !((state_d == StWaitResp) || (state_d == StReceive));
      end
   end

   coax_fifo #(
      .Width (WordWidth),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (fifo_clear),
      .push  (fifo_push),
      .wdata (rx_data),
      .pop   (fifo_read),
      .rdata (fifo_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (word_count)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign rx_reset = rx_reset_q;
   assign timeout  = timeout_q;
   assign error    = error_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_coax_link_ctrl.sv
// Self-checking bench for coax_link_ctrl (TURNAROUND 16, TIMEOUT 512, FIFO depth 4).
module tb_coax_link_ctrl;

   localparam int unsigned Turn  = 16;
   localparam int unsigned Resp  = 512;
   localparam int unsigned Depth = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       busy, done;
   logic       tx_active = 1'b0;
   logic       rx_reset;
   logic       rx_active = 1'b0;
   logic [9:0] rx_data = '0;
   logic       rx_strobe = 1'b0;
   logic       rx_error = 1'b0;
   logic [9:0] fifo_data;
   logic       fifo_empty;
   logic       fifo_read = 1'b0;
   logic [2:0] word_count;
   logic       timeout, error, overflow;

   int errs = 0;
   int checks = 0;
   int done_seen = 0;
   int model_cnt = 0;
   logic [9:0] exp_q[$];

   coax_link_ctrl #(
      .TURNAROUND_CLOCKS       (Turn),
      .RESPONSE_TIMEOUT_CLOCKS (Resp),
      .FIFO_DEPTH              (Depth)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .tx_active  (tx_active),
      .rx_reset   (rx_reset),
      .rx_active  (rx_active),
      .rx_data    (rx_data),
      .rx_strobe  (rx_strobe),
      .rx_error   (rx_error),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_read  (fifo_read),
      .word_count (word_count),
      .timeout    (timeout),
      .error      (error),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Count done pulses away from the active edge.
   always @(negedge clk) if (done) done_seen++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_txn();
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_q.delete();
      model_cnt = 0;
   endtask

   task automatic do_tx(input int n);
      tx_active = 1'b1;
      repeat (n) tick();
      tx_active = 1'b0;
   endtask

   // Returns the number of edges until rx_reset drops (bounded).
   task automatic wait_listen(output int n);
      n = 0;
      while (rx_reset && n < 100) begin
         tick();
         n++;
      end
   endtask

   // Drive one strobe; the model accepts it only while the FIFO has room.
   task automatic strobe_word(input logic [9:0] w, input bit last, input bit expect_push);
      rx_strobe = 1'b1;
      rx_data   = w;
      if (last) rx_active = 1'b0;
      if (expect_push && model_cnt < int'(Depth)) begin
         exp_q.push_back(w);
         model_cnt++;
      end
      tick();
      rx_strobe = 1'b0;
   endtask

   task automatic read_all();
      while (exp_q.size() > 0) begin
         check_eq("rd_data", 32'(fifo_data), 32'(exp_q.pop_front()));
         fifo_read = 1'b1;
         tick();
         fifo_read = 1'b0;
      end
      model_cnt = 0;
      check_eq("rd_empty", 32'(fifo_empty), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_rx_reset"}, 32'(rx_reset), 32'd1);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_status"}, {29'd0, timeout, error, overflow}, 32'd0);
      check_eq({tag, "_empty"}, 32'(fifo_empty), 32'd1);
      check_eq({tag, "_count"}, 32'(word_count), 32'd0);
      check_eq({tag, "_data"}, 32'(fifo_data), 32'd0);
   endtask

   initial begin
      int n;
      int d0;
      bit echo_bad;

      // Reset state
      repeat (2) tick();
      check_reset_vals("rst");
      reset = 1'b0;
      tick();

      // Normal transaction with echo rejection during TX and TURNAROUND
      start_txn();
      check_eq("norm_busy", 32'(busy), 32'd1);
      echo_bad = 1'b0;
      rx_strobe = 1'b1;
      rx_data = 10'h2AA;
      tx_active = 1'b1;
      repeat (40) begin
         tick();
         if (!rx_reset) echo_bad = 1'b1;
      end
      tx_active = 1'b0;
      wait_listen(n);
      rx_strobe = 1'b0;
      check_eq("echo_rx_reset", 32'(echo_bad), 32'd0);
      // First tick is the edge that samples tx_active low; release comes Turn edges later.
      check_eq("turn_len", 32'(n), 32'(Turn + 1));
      check_eq("echo_count", 32'(word_count), 32'd0);
      repeat (5) tick();
      d0 = done_seen;
      rx_active = 1'b1;
      tick();
      strobe_word(10'h00A, 1'b0, 1'b1);
      strobe_word(10'h3FF, 1'b0, 1'b1);
      strobe_word(10'h155, 1'b1, 1'b1);
      check_eq("norm_done", 32'(done), 32'd1);
      check_eq("norm_rx_reset", 32'(rx_reset), 32'd1);
      repeat (3) tick();
      check_eq("norm_done_once", 32'(done_seen - d0), 32'd1);
      check_eq("norm_busy_end", 32'(busy), 32'd0);
      check_eq("norm_count", 32'(word_count), 32'd3);
      check_eq("norm_status", {29'd0, timeout, error, overflow}, 32'd0);
      read_all();

      // Timeout: no response after turnaround
      start_txn();
      do_tx(3);
      wait_listen(n);
      check_eq("to_listen", 32'(rx_reset), 32'd0);
      d0 = done_seen;
      n = 0;
      while (!done && n < 1000) begin
         tick();
         n++;
      end
      check_eq("to_latency", 32'(n), 32'(Resp));
      check_eq("to_flag", 32'(timeout), 32'd1);
      check_eq("to_count", 32'(word_count), 32'd0);
      repeat (2) tick();
      check_eq("to_done_once", 32'(done_seen - d0), 32'd1);

      // Overflow: six words into a four-deep FIFO
      start_txn();
      check_eq("ovf_clear_to", 32'(timeout), 32'd0);
      do_tx(3);
      wait_listen(n);
      rx_active = 1'b1;
      tick();
      for (int i = 1; i <= 6; i++) strobe_word(10'(i), (i == 6), 1'b1);
      tick();
      check_eq("ovf_flag", 32'(overflow), 32'd1);
      check_eq("ovf_count", 32'(word_count), 32'd4);
      read_all();

      // Receive error mid-frame
      start_txn();
      do_tx(3);
      wait_listen(n);
      rx_active = 1'b1;
      tick();
      strobe_word(10'h011, 1'b0, 1'b1);
      rx_error = 1'b1;
`ifdef COAX_LINK_ERROR_ABORT_EN
      strobe_word(10'h022, 1'b0, 1'b0);
      rx_error = 1'b0;
      check_eq("err_flag", 32'(error), 32'd1);
      check_eq("err_done", 32'(done), 32'd1);
      rx_active = 1'b0;
      tick();
`else
      strobe_word(10'h022, 1'b0, 1'b1);
      rx_error = 1'b0;
      check_eq("err_flag", 32'(error), 32'd1);
      check_eq("err_continue", {30'd0, busy, done}, 32'd2);
      strobe_word(10'h033, 1'b1, 1'b1);
`endif
      tick();
      check_eq("err_hold", 32'(error), 32'd1);
      check_eq("err_count", 32'(word_count), 32'(exp_q.size()));
      read_all();

      // Abort while waiting for a response
      start_txn();
      do_tx(3);
      wait_listen(n);
      d0 = done_seen;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_rx_reset", 32'(rx_reset), 32'd1);
      repeat (3) tick();
      check_eq("abort_no_done", 32'(done_seen - d0), 32'd0);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check_eq("abort_beats_start", 32'(busy), 32'd0);

      // Reset in the middle of RECEIVE, then a normal transaction
      start_txn();
      do_tx(3);
      wait_listen(n);
      rx_active = 1'b1;
      tick();
      strobe_word(10'h0F0, 1'b0, 1'b1);
      strobe_word(10'h00F, 1'b0, 1'b1);
      reset = 1'b1;
      tick();
      check_reset_vals("mid_rst");
      reset = 1'b0;
      rx_active = 1'b0;
      exp_q.delete();
      model_cnt = 0;
      tick();
      start_txn();
      do_tx(3);
      wait_listen(n);
      check_eq("post_rst_listen", 32'(rx_reset), 32'd0);
      rx_active = 1'b1;
      tick();
      strobe_word(10'h1C3, 1'b1, 1'b1);
      check_eq("post_rst_done", 32'(done), 32'd1);
      tick();
      check_eq("post_rst_count", 32'(word_count), 32'd1);
      read_all();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
